// File: rtl/intdiv.sv
// rtl/intdiv.sv - iterative unsigned divider, 2*LOGQ-bit dividend by LOGQ-bit divisor
//
// Multi-cycle shift-subtract divider with valid/ready handshakes on both sides.
// One operation is in flight at a time. Operands are latched on the accept edge.
// Quotient and remainder stay stable while the result waits for out_ready.
//
// Build option: INTDIV_RADIX4_EN
//   undefined : radix-2 restoring, one quotient bit per RUN cycle, ITER = 2*LOGQ
//   defined   : radix-4, two quotient bits per RUN cycle, ITER = LOGQ
//   Results and handshake behaviour are the same in both builds. Only the latency differs.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   in_valid   dividend/divisor offered
//   in_ready   unit idle and able to accept (low while rst is asserted)
//   in_c       dividend, 2*LOGQ bits
//   in_q       divisor, LOGQ bits
//   out_valid  result presented and held
//   out_ready  consumer accepts result
//   out_quo    quotient floor(in_c / in_q), all ones on divide-by-zero
//   out_rem    remainder in_c mod in_q, in_c[LOGQ-1:0] on divide-by-zero
//   out_dz     divide-by-zero flag for the presented result

module intdiv #(
    parameter int LOGQ = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2*LOGQ-1:0] in_c,
    input  logic [LOGQ-1:0]   in_q,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*LOGQ-1:0] out_quo,
    output logic [LOGQ-1:0]   out_rem,
    output logic              out_dz
);

    localparam int DW = 2 * LOGQ;
`ifdef INTDIV_RADIX4_EN
    localparam int ITER = LOGQ;
    localparam int RW   = LOGQ + 2;
`else
    localparam int ITER = DW;
    localparam int RW   = LOGQ + 1;
`endif
    localparam int            CW       = $clog2(ITER + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(ITER - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [LOGQ-1:0] q_q;
    // The settled remainder is always < q, so LOGQ bits hold it. The extra
    // partial-remainder bits exist only in the shifted value inside a step.
    logic [LOGQ-1:0] rem_q;
    // Shift register: dividend bits leave at the top while quotient bits enter at the bottom.
    logic [DW-1:0]   quo_q;
    logic            out_valid_q;
    logic            out_dz_q;

    logic [LOGQ-1:0] rem_d;
    logic [DW-1:0]   quo_d;
    logic [RW-1:0]   sh;

`ifdef INTDIV_RADIX4_EN
    logic [RW-1:0] q3_q;
    logic [RW-1:0] m1;
    logic [RW-1:0] m2;

    // Radix-4 step: bring in two dividend bits, then subtract the largest of
    // 3q/2q/q that fits. The chosen digit becomes the next two quotient bits.
    always_comb begin
        sh    = {rem_q, quo_q[DW-1:DW-2]};
        m1    = {2'b00, q_q};
        m2    = {1'b0, q_q, 1'b0};
        rem_d = rem_q;
        quo_d = quo_q;
        if (sh >= q3_q) begin
            rem_d = LOGQ'(sh - q3_q);
            quo_d = {quo_q[DW-3:0], 2'd3};
        end else if (sh >= m2) begin
            rem_d = LOGQ'(sh - m2);
            quo_d = {quo_q[DW-3:0], 2'd2};
        end else if (sh >= m1) begin
            rem_d = LOGQ'(sh - m1);
            quo_d = {quo_q[DW-3:0], 2'd1};
        end else begin
            rem_d = LOGQ'(sh);
            quo_d = {quo_q[DW-3:0], 2'd0};
        end
    end
`else
    // Radix-2 restoring step: bring in one dividend bit, then subtract q if it fits.
    always_comb begin
        sh    = {rem_q, quo_q[DW-1]};
        rem_d = rem_q;
        quo_d = quo_q;
        if (sh >= {1'b0, q_q}) begin
            rem_d = LOGQ'(sh - {1'b0, q_q});
            quo_d = {quo_q[DW-2:0], 1'b1};
        end else begin
            rem_d = LOGQ'(sh);
            quo_d = {quo_q[DW-2:0], 1'b0};
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            q_q         <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            out_valid_q <= 1'b0;
            out_dz_q    <= 1'b0;
`ifdef INTDIV_RADIX4_EN
            q3_q        <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        q_q <= in_q;
`ifdef INTDIV_RADIX4_EN
                        q3_q <= {2'b00, in_q} + {1'b0, in_q, 1'b0};
`endif
                        if (in_q == '0) begin
                            // Divide-by-zero does not iterate. The result is presented on the next cycle.
                            quo_q       <= '1;
                            rem_q       <= in_c[LOGQ-1:0];
                            out_dz_q    <= 1'b1;
                            out_valid_q <= 1'b1;
                            state_q     <= S_DONE;
                        end else begin
                            quo_q    <= in_c;
                            rem_q    <= '0;
                            out_dz_q <= 1'b0;
                            cnt_q    <= CNT_LOAD;
                            state_q  <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    if (cnt_q == '0) begin
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Gated by rst so in_ready is low while reset is held. It goes high as soon as reset is released.
    assign in_ready  = rst && (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign out_quo   = quo_q;
    assign out_rem   = rem_q;
    assign out_dz    = out_dz_q;

endmodule

// File: tb/tb_intdiv.sv
// tb/tb_intdiv.sv - scoreboard bench for intdiv at LOGQ=8 and LOGQ=64

module tb_intdiv;

`ifdef INTDIV_RADIX4_EN
    localparam int ITER8  = 8;
    localparam int ITER64 = 64;
`else
    localparam int ITER8  = 16;
    localparam int ITER64 = 128;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         iv8, ir8, ov8, or8, dz8;
    logic [15:0]  c8, quo8;
    logic [7:0]   q8, rem8;
    logic         iv64, ir64, ov64, or64, dz64;
    logic [127:0] c64, quo64;
    logic [63:0]  q64, rem64;

    intdiv #(.LOGQ(8)) u_d8 (
        .clk(clk), .rst(rst_n),
        .in_valid(iv8), .in_ready(ir8), .in_c(c8), .in_q(q8),
        .out_valid(ov8), .out_ready(or8), .out_quo(quo8), .out_rem(rem8), .out_dz(dz8)
    );

    intdiv #(.LOGQ(64)) u_d64 (
        .clk(clk), .rst(rst_n),
        .in_valid(iv64), .in_ready(ir64), .in_c(c64), .in_q(q64),
        .out_valid(ov64), .out_ready(or64), .out_quo(quo64), .out_rem(rem64), .out_dz(dz64)
    );

    typedef struct packed {
        logic [127:0] quo;
        logic [63:0]  rem;
        logic         dz;
    } exp_t;

    exp_t sb8[$];
    exp_t sb64[$];
    exp_t e8, e64;
    int   acc8[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer division on the operand width L.
    function automatic exp_t model(input int L, input logic [127:0] c, input logic [63:0] q);
        exp_t r;
        logic [127:0] dm;
        logic [63:0]  rm;
        dm = '1;
        dm = dm >> (128 - 2 * L);
        rm = '1;
        rm = rm >> (64 - L);
        if (q == 64'd0) begin
            r.quo = dm;
            r.rem = c[63:0] & rm;
            r.dz  = 1'b1;
        end else begin
            r.quo = (c & dm) / {64'd0, q};
            r.rem = 64'((c & dm) % {64'd0, q});
            r.dz  = 1'b0;
        end
        return r;
    endfunction

    // Accept-side monitor pushes the expected result. The result-side monitor pops and compares it.
    always @(negedge clk) begin
        if (rst_n && iv8 && ir8) begin
            sb8.push_back(model(8, {112'd0, c8}, {56'd0, q8}));
            acc8.push_back(cyc);
        end
        if (rst_n && iv64 && ir64)
            sb64.push_back(model(64, c64, q64));
        if (ir8 && ov8) chk("d8 ready/valid overlap", 128'(1), 128'(0));
        if (ir64 && ov64) chk("d64 ready/valid overlap", 128'(1), 128'(0));
        if (rst_n && ov8 && or8) begin
            if (sb8.size() == 0) chk("d8 unexpected result", 128'(1), 128'(0));
            else begin
                e8 = sb8.pop_front();
                chk("d8 quo", {112'd0, quo8}, e8.quo);
                chk("d8 rem", {120'd0, rem8}, {64'd0, e8.rem});
                chk("d8 dz", 128'(dz8), 128'(e8.dz));
            end
        end
        if (rst_n && ov64 && or64) begin
            if (sb64.size() == 0) chk("d64 unexpected result", 128'(1), 128'(0));
            else begin
                e64 = sb64.pop_front();
                chk("d64 quo", quo64, e64.quo);
                chk("d64 rem", {64'd0, rem64}, {64'd0, e64.rem});
                chk("d64 dz", 128'(dz64), 128'(e64.dz));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input bit big, input logic [127:0] c, input logic [63:0] q);
        int n;
        n = 0;
        while (!(big ? ir64 : ir8) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) chk("start timeout", 128'(0), 128'(1));
        if (big) begin
            iv64 = 1'b1; c64 = c; q64 = q;
        end else begin
            iv8 = 1'b1; c8 = c[15:0]; q8 = q[7:0];
        end
        tick();
        iv8 = 1'b0;
        iv64 = 1'b0;
    endtask

    task automatic wait_ov(input bit big, output int lat);
        lat = 0;
        while (!(big ? ov64 : ov8) && lat < 400) begin
            tick();
            lat++;
        end
        if (lat >= 400) chk("result timeout", 128'(0), 128'(1));
    endtask

    // Leaves the result presented. The caller ticks to let it be consumed.
    task automatic op(input bit big, input logic [127:0] c, input logic [63:0] q);
        int lat;
        int want;
        logic [63:0] qe;
        qe = big ? q : {56'd0, q[7:0]};
        want = (qe == 64'd0) ? 0 : (big ? ITER64 : ITER8);
        start(big, c, q);
        wait_ov(big, lat);
        chk(big ? "d64 latency" : "d8 latency", 128'(lat), 128'(want));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int lat;
        int n;
        exp_t e;
        logic [127:0] c;
        logic [63:0]  q;

        iv8 = 0; c8 = 0; q8 = 0; or8 = 1;
        iv64 = 0; c64 = 0; q64 = 0; or64 = 1;

        repeat (2) @(posedge clk);
        #1;
        chk("in_ready in reset", 128'(ir8), 128'(0));
        chk("out_valid in reset", 128'(ov8), 128'(0));
        rst_n = 1'b1;
        #1;
        chk("in_ready after reset", 128'(ir8), 128'(1));
        chk("d64 in_ready after reset", 128'(ir64), 128'(1));
        chk("out_valid after reset", 128'(ov8), 128'(0));
        chk("out_quo after reset", 128'(quo8), 128'(0));
        chk("out_rem after reset", 128'(rem8), 128'(0));
        chk("out_dz after reset", 128'(dz8), 128'(0));
        tick();

        op(0, 128'd1000, 64'd7);
        chk("1000/7 quo", 128'(quo8), 128'(142));
        chk("1000/7 rem", 128'(rem8), 128'(6));
        chk("1000/7 dz", 128'(dz8), 128'(0));
        tick();

        op(0, 128'h1234, 64'd0);
        chk("dz flag", 128'(dz8), 128'(1));
        chk("dz quo", 128'(quo8), 128'hFFFF);
        chk("dz rem", 128'(rem8), 128'h34);
        tick();

        op(1, (128'd3 << 64) + 128'd5, 64'h8000_0000_0000_0000);
        chk("wide quo 6", quo64, 128'd6);
        chk("wide rem 5", 128'(rem64), 128'd5);
        tick();

        op(1, {128{1'b1}}, 64'd1);
        chk("wide max quo", quo64, {128{1'b1}});
        chk("wide max rem", 128'(rem64), 128'd0);
        tick();

        repeat (24) begin
            c = 128'($urandom);
            q = ($urandom_range(0, 5) == 0) ? 64'd0 : 64'($urandom_range(1, 255));
            op(0, c, q);
            tick();
        end

        repeat (8) begin
            c = {$urandom, $urandom, $urandom, $urandom};
            case ($urandom_range(0, 5))
                0: q = 64'd0;
                1: q = 64'($urandom_range(1, 1000));
                2: q = {$urandom, $urandom} >> $urandom_range(0, 62);
                default: q = {$urandom, $urandom};
            endcase
            op(1, c, q);
            tick();
        end

        // Backpressure: result held for 5 cycles, then accepted on the 6th cycle.
        or8 = 1'b0;
        c = 128'($urandom);
        q = 64'($urandom_range(1, 255));
        e = model(8, {112'd0, c[15:0]}, q);
        start(0, c, q);
        wait_ov(0, lat);
        for (int k = 0; k < 5; k++) begin
            chk("bp out_valid held", 128'(ov8), 128'(1));
            chk("bp in_ready low", 128'(ir8), 128'(0));
            chk("bp quo stable", 128'(quo8), e.quo);
            chk("bp rem stable", 128'(rem8), 128'(e.rem));
            tick();
        end
        chk("bp out_valid 6th", 128'(ov8), 128'(1));
        or8 = 1'b1;
        tick();
        chk("bp out_valid dropped", 128'(ov8), 128'(0));
        chk("bp in_ready back", 128'(ir8), 128'(1));

        // Operand changes and a held in_valid during RUN must be ignored.
        start(0, 128'd200, 64'd9);
        for (int k = 0; k < ITER8 - 2; k++) begin
            iv8 = 1'b1;
            c8 = 16'($urandom);
            q8 = 8'($urandom);
            chk("run in_ready low", 128'(ir8), 128'(0));
            tick();
        end
        iv8 = 1'b0;
        wait_ov(0, lat);
        chk("latched quo 200/9", 128'(quo8), 128'(22));
        chk("latched rem 200/9", 128'(rem8), 128'(2));
        tick();

        // Back-to-back throughput with in_valid held high.
        acc8.delete();
        iv8 = 1'b1;
        n = 0;
        while (acc8.size() < 4 && n < 400) begin
            c8 = 16'($urandom);
            q8 = 8'($urandom_range(1, 255));
            tick();
            n++;
        end
        iv8 = 1'b0;
        chk("throughput accepts", 128'(acc8.size()), 128'(4));
        if (acc8.size() == 4)
            for (int i = 1; i < 4; i++)
                chk("throughput spacing", 128'(acc8[i] - acc8[i-1]), 128'(ITER8 + 2));
        wait_ov(0, lat);
        tick();

        // Reset during RUN aborts the operation, and the next division is clean.
        start(0, 128'($urandom), 64'($urandom_range(1, 255)));
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        sb8.delete();
        chk("abort in_ready low", 128'(ir8), 128'(0));
        chk("abort out_valid low", 128'(ov8), 128'(0));
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        chk("abort in_ready after", 128'(ir8), 128'(1));
        chk("abort out_valid after", 128'(ov8), 128'(0));
        op(0, 128'd255, 64'd16);
        chk("255/16 quo", 128'(quo8), 128'(15));
        chk("255/16 rem", 128'(rem8), 128'(15));
        tick();

        repeat (3) tick();
        chk("d8 scoreboard empty", 128'(sb8.size()), 128'(0));
        chk("d64 scoreboard empty", 128'(sb64.size()), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intdiv.md
# intdiv

Iterative unsigned integer divider: the inverse of the pipelined tiled multiplier. It accepts a 2·LOGQ-bit dividend, such as a full product word, and a LOGQ-bit divisor, and returns the 2·LOGQ-bit quotient and the LOGQ-bit remainder. The modmul datapath uses it as a golden-reference and fallback reducer (x mod q for arbitrary runtime q), and the bench uses it to cross-check multiplier outputs. It is a single-issue, multi-cycle, shift-subtract unit with valid/ready handshakes on both sides.

## Interface
- LOGQ, default 64: divisor/remainder width; dividend/quotient width is 2·LOGQ; legal range 2..128.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  dividend/divisor offered.
- in_ready  out  1  unit can accept; high only in IDLE.
- in_c  in  2·LOGQ  dividend.
- in_q  in  LOGQ  divisor.
- out_valid  out  1  result held stable.
- out_ready  in  1  consumer accepts result.
- out_quo  out  2·LOGQ  quotient floor(in_c / in_q).
- out_rem  out  LOGQ  remainder in_c mod in_q.
- out_dz  out  1  divide-by-zero flag for this result.

## Operation
- FSM states: IDLE, RUN, DONE. Reset to IDLE. Reset values: in_ready=1 after reset release (0 while rst low), out_valid=0, out_quo=0, out_rem=0, out_dz=0, iteration counter=0.
- IDLE: in_ready=1. On in_valid&&in_ready, latch in_c into the quotient/shift register, latch in_q, and clear the partial remainder (LOGQ+1 bits). If in_q==0, go to DONE with out_quo=all ones, out_rem=in_c[LOGQ-1:0], out_dz=1. Otherwise go to RUN, counter=ITER-1.
- RUN: each cycle, restoring step: shift {rem, quo} left by 1 bit. If the shifted remainder ≥ q, subtract q and set the quotient LSB to 1; else set it to 0. Decrement the counter. When the counter is 0 this cycle, go to DONE.
- Partial remainder is LOGQ+1 bits wide so the shifted value never overflows. The remainder is always < q. No quotient overflow is possible, because quotient width equals dividend width.
- DONE: out_valid=1; outputs held stable. On out_ready, go to IDLE and drop out_valid. The accepting edge does not also take a new input, because in_ready is low in DONE.
- in_c/in_q are sampled only on the accept edge. Later changes are ignored.
- Reset asserted in any state aborts immediately. The in-flight result is discarded and no out_valid is produced for it.

## Timing
- ITER = 2·LOGQ (radix-2) or LOGQ (radix-4).
- Accept edge = edge 0. Nonzero divisor: out_valid is first visible after edge ITER, so the latency is ITER cycles.
- Zero divisor: out_valid is visible after edge 0, so the latency is 1 cycle.
- Throughput: one result per ITER+2 cycles with out_ready held high (accept, ITER steps, one DONE cycle, one IDLE cycle).
- out_valid stays high, with outputs unchanged, for any number of cycles while out_ready is low.
- in_ready and out_valid are never high in the same cycle.

## Configuration
- INTDIV_RADIX4_EN defined: two quotient bits per RUN cycle, so ITER=LOGQ.
  - Each step shifts the remainder by 2 bits and compares it against q, 2q and 3q; 3q is precomputed once at accept.
  - The largest multiple ≤ the remainder is subtracted, and the selected digit 0..3 is shifted into the quotient.
  - The partial remainder is LOGQ+2 bits wide.
- Undefined: radix-2 restoring, ITER=2·LOGQ.
- The handshake, the divide-by-zero behaviour and all results are identical in both builds; only the latency differs.

## Test plan
- LOGQ=8, in_c=1000, in_q=7 -> out_quo=142, out_rem=6, out_dz=0; out_valid after exactly 16 cycles (8 with INTDIV_RADIX4_EN).
- LOGQ=64, in_c=3·2^64+5, in_q=2^63 -> out_quo=6, out_rem=5; in_c=2^128−1, in_q=1 -> out_quo=2^128−1, out_rem=0.
- LOGQ=8, in_q=0, in_c=0x1234 -> out_dz=1, out_quo=0xFFFF, out_rem=0x34, out_valid one cycle after accept.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> outputs stable and in_ready=0 throughout; accepted on the 6th cycle, then in_ready=1 the next cycle.
- Change in_c/in_q and hold in_valid high during RUN -> no second accept and the result matches the originally latched operands; back-to-back ops with out_ready=1 complete one per ITER+2 cycles.
- Drive rst low at RUN iteration 5, then release -> out_valid=0, in_ready=1 after release; the next division (255/16, LOGQ=8) -> quotient 15, remainder 15.
